// File: rtl/tlm_sync_fifo.sv
// Single-clock show-ahead FIFO with blocking or drop-on-full put side,
// registered fill-level flags, flush and a saturating drop counter.
module tlm_sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter bit BLOCKING = 1'b1,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       put_valid,
    input  logic [WIDTH-1:0]           put_data,
    output logic                       put_ready,
    output logic                       get_valid,
    output logic [WIDTH-1:0]           get_data,
    input  logic                       get_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [15:0]                drop_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      drop_q, drop_d;
    logic             full_q, empty_q, af_q, ae_q;
    logic             put_fire, get_fire;

    assign put_fire = put_valid & ~full_q & ~flush;
    assign get_fire = ~empty_q & get_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (put_fire)
                wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (get_fire)
                rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (put_fire && !get_fire)
                count_d = count_q + 1'b1;
            else if (get_fire && !put_fire)
                count_d = count_q - 1'b1;
            // A full FIFO never frees a slot for the same-cycle put in try_put mode either
            if (!BLOCKING && put_valid && full_q && drop_q != 16'hFFFF)
                drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= (AF_LEVEL == 0);
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            af_q     <= (32'(count_d) >= 32'(AF_LEVEL));
            ae_q     <= (32'(count_d) <= 32'(AE_LEVEL));
        end
    end

    // Storage is deliberately left out of reset; contents are dead once pointers clear
    always_ff @(posedge clk) begin
        if (put_fire)
            mem_q[wr_ptr_q] <= put_data;
    end

    assign put_ready    = BLOCKING ? ~full_q : 1'b1;
    assign get_valid    = ~empty_q;
    assign get_data     = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_tlm_sync_fifo.sv
// Directed bench over three FIFO configurations, checked against a queue scoreboard
// and an occupancy/drop model kept inside the bench.
module tb_tlm_sync_fifo;
    localparam int DEP [3] = '{16, 5, 4};
    localparam int BLK [3] = '{1, 1, 0};
    localparam int AFL [3] = '{14, 3, 2};
    localparam int AEL [3] = '{2, 2, 2};

    logic        clk, rst_n;
    logic [2:0]  pvv, grv, flv;
    logic [31:0] pdv [3];
    logic [2:0]  pr, gv, fu, em, af, ae;
    logic [31:0] gd [3];
    logic [15:0] dc [3];
    logic [4:0]  c0;
    logic [2:0]  c1, c2;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb [$];
    int          mcnt  = 0;
    int          mdrop = 0;

    tlm_sync_fifo #(.WIDTH(32), .DEPTH(16), .BLOCKING(1'b1), .AF_LEVEL(14), .AE_LEVEL(2)) u_a (
        .clk(clk), .rst_n(rst_n), .put_valid(pvv[0]), .put_data(pdv[0]), .put_ready(pr[0]),
        .get_valid(gv[0]), .get_data(gd[0]), .get_ready(grv[0]), .flush(flv[0]), .count(c0),
        .full(fu[0]), .empty(em[0]), .almost_full(af[0]), .almost_empty(ae[0]), .drop_cnt(dc[0]));

    tlm_sync_fifo #(.WIDTH(32), .DEPTH(5), .BLOCKING(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .put_valid(pvv[1]), .put_data(pdv[1]), .put_ready(pr[1]),
        .get_valid(gv[1]), .get_data(gd[1]), .get_ready(grv[1]), .flush(flv[1]), .count(c1),
        .full(fu[1]), .empty(em[1]), .almost_full(af[1]), .almost_empty(ae[1]), .drop_cnt(dc[1]));

    tlm_sync_fifo #(.WIDTH(32), .DEPTH(4), .BLOCKING(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .put_valid(pvv[2]), .put_data(pdv[2]), .put_ready(pr[2]),
        .get_valid(gv[2]), .get_data(gd[2]), .get_ready(grv[2]), .flush(flv[2]), .count(c2),
        .full(fu[2]), .empty(em[2]), .almost_full(af[2]), .almost_empty(ae[2]), .drop_cnt(dc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        case (k)
            0:       return 32'(c0);
            1:       return 32'(c1);
            default: return 32'(c2);
        endcase
    endfunction

    // Compare registered status of instance k with the model occupancy
    task automatic check_state(input int k, input int mc, input int md);
        chk($sformatf("count[%0d]", k), cnt_of(k), 32'(mc));
        chk($sformatf("full[%0d]", k), 32'(fu[k]), 32'(mc == DEP[k]));
        chk($sformatf("empty[%0d]", k), 32'(em[k]), 32'(mc == 0));
        chk($sformatf("almost_full[%0d]", k), 32'(af[k]), 32'(mc >= AFL[k]));
        chk($sformatf("almost_empty[%0d]", k), 32'(ae[k]), 32'(mc <= AEL[k]));
        chk($sformatf("drop_cnt[%0d]", k), 32'(dc[k]), 32'(md));
        chk($sformatf("get_valid[%0d]", k), 32'(gv[k]), 32'(mc != 0));
        if (mc != 0 && k == 0 || mc != 0 && k != 0)
            chk($sformatf("peek[%0d]", k), gd[k], sb[0]);
    endtask

    // One clock of stimulus on instance k, with scoreboard and model updates
    task automatic cyc(input int k, input logic pv, input logic [31:0] pd, input logic gr, input logic fl);
        bit full_m, pf, gf;
        pvv[k] = pv; pdv[k] = pd; grv[k] = gr; flv[k] = fl;
        full_m = (mcnt == DEP[k]);
        pf = pv && !full_m && !fl;
        gf = (mcnt != 0) && gr && !fl;
        chk($sformatf("put_ready[%0d]", k), 32'(pr[k]), (BLK[k] != 0) ? 32'(!full_m) : 32'd1);
        if (gf) begin
            chk($sformatf("get_data[%0d]", k), gd[k], sb[0]);
            void'(sb.pop_front());
        end
        if (pv && full_m && !fl && BLK[k] == 0 && mdrop != 16'hFFFF) mdrop++;
        if (fl) begin
            sb.delete();
            mcnt = 0;
        end else begin
            if (pf) sb.push_back(pd);
            mcnt = mcnt + int'(pf) - int'(gf);
        end
        @(posedge clk); #1;
        pvv[k] = 1'b0; grv[k] = 1'b0; flv[k] = 1'b0;
        check_state(k, mcnt, mdrop);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pvv = '0; grv = '0; flv = '0;
        sb.delete();
        mcnt = 0;
        mdrop = 0;
        for (int k = 0; k < 3; k++) check_state(k, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        pvv = '0; grv = '0; flv = '0;
        for (int k = 0; k < 3; k++) pdv[k] = '0;
        @(posedge clk); #1;
        do_reset();

        // Three back-to-back puts, then drain
        for (int i = 1; i <= 3; i++) cyc(0, 1'b1, 32'(i), 1'b0, 1'b0);
        cyc(0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(0, 1'b0, 0, 1'b1, 1'b0);

        // Fill to full with backpressure; word 16 waits for a free slot
        for (int i = 0; i <= 16; i++) cyc(0, 1'b1, 32'(i), 1'b0, 1'b0);
        cyc(0, 1'b1, 32'd16, 1'b0, 1'b0);
        cyc(0, 1'b1, 32'd16, 1'b1, 1'b0);
        cyc(0, 1'b1, 32'd16, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(0, 1'b0, 0, 1'b1, 1'b0);

        // Flush at count 8 overrides a simultaneous put and get
        for (int i = 0; i < 8; i++) cyc(0, 1'b1, 32'(200 + i), 1'b0, 1'b0);
        cyc(0, 1'b1, 32'd999, 1'b1, 1'b1);
        cyc(0, 1'b0, 0, 1'b0, 1'b0);
        cyc(0, 1'b1, 32'd300, 1'b0, 1'b0);
        cyc(0, 1'b0, 0, 1'b1, 1'b0);

        // Almost-full/empty thresholds, then reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 14; i++) cyc(0, 1'b1, 32'(400 + i), 1'b0, 1'b0);
        cyc(0, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) cyc(0, 1'b0, 0, 1'b1, 1'b0);
        pvv[0] = 1'b1; pdv[0] = 32'd777; grv[0] = 1'b1;
        do_reset();

        // Non power-of-two depth: interleaved put/get wraps pointers
        cyc(1, 1'b1, 32'd100, 1'b0, 1'b0);
        for (int i = 1; i < 12; i++) cyc(1, 1'b1, 32'(100 + i), 1'b1, 1'b0);
        cyc(1, 1'b0, 0, 1'b1, 1'b0);

        // try_put mode: overflow drops are counted and the held words survive
        for (int i = 10; i <= 15; i++) cyc(2, 1'b1, 32'(i), 1'b0, 1'b0);
        cyc(2, 1'b1, 32'd50, 1'b0, 1'b1);
        cyc(2, 1'b1, 32'd60, 1'b0, 1'b0);
        cyc(2, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 10; i <= 13; i++) cyc(2, 1'b1, 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(2, 1'b0, 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
